// File: rtl/msg_schedule.sv
// SHA-256 message schedule: loads a 16-word block over MA/MD and
// streams the expanded words W0..W63 over a valid/ready handshake.
module msg_schedule (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic [7:0]  MA,
    input  logic [31:0] MD,
    output logic [31:0] W,
    output logic [5:0]  T,
    output logic        W_VLD,
    input  logic        W_RDY,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_t;
    logic [3:0]  r_ma;
    logic [31:0] r_win [16];
    logic [31:0] r_w;
    logic [5:0]  r_tout;
    logic        r_vld;
    logic        r_busy;
    logic        r_done;

    logic        w_start;
    logic        w_produce;
    logic        w_xfer;
    logic        w_fin;
    logic [31:0] w_x;
    logic [3:0]  w_ma_nxt;

    function automatic logic [31:0] f_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign w_xfer    = r_vld && W_RDY;
    assign w_produce = (r_state == S_RUN) && (!r_vld || W_RDY);
    assign w_start   = (r_state == S_IDLE) && START;
    assign w_fin     = (r_state == S_FLUSH) && w_xfer;

    // New schedule word: message word for the first 16 rounds, expansion after.
    always_comb begin
        w_x = MD;
        if (r_t >= 6'd16) begin
            w_x = f_s1(r_win[14]) + r_win[9] + f_s0(r_win[1]) + r_win[0];
        end
    end

    // Address of the next message word, saturating at the last word.
    always_comb begin
        w_ma_nxt = r_t[3:0] + 4'd1;
        if (r_t >= 6'd15) begin
            w_ma_nxt = 4'd15;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_produce && (r_t == 6'd63)) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_xfer) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Round counter, address, sliding window and output register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_t    <= '0;
            r_ma   <= '0;
            r_w    <= '0;
            r_tout <= '0;
            r_vld  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_t    <= '0;
                r_ma   <= '0;
                r_busy <= 1'b1;
            end
            if (w_produce) begin
                for (int i = 0; i < 15; i++) begin
                    r_win[i] <= r_win[i+1];
                end
                r_win[15] <= w_x;
                r_w       <= w_x;
                r_tout    <= r_t;
                r_vld     <= 1'b1;
                r_t       <= r_t + 6'd1;
                r_ma      <= w_ma_nxt;
            end
            if (w_fin) begin
                r_vld  <= 1'b0;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign MA    = {4'b0000, r_ma};
    assign W     = r_w;
    assign T     = r_tout;
    assign W_VLD = r_vld;
    assign BUSY  = r_busy;
    assign DONE  = r_done;

endmodule

// File: tb/tb_msg_schedule.sv
// Scoreboard bench for msg_schedule: a reference model pushes expected
// words; a negedge monitor pops and compares on every transfer.
module tb_msg_schedule;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [7:0]  MA;
    logic [31:0] MD;
    logic [31:0] W;
    logic [5:0]  T;
    logic        W_VLD;
    logic        W_RDY;
    logic        BUSY;
    logic        DONE;

    logic [31:0] mem [16];
    logic [31:0] alt [16];
    logic        alt_sel;

    int          checks = 0;
    int          failures = 0;
    logic [37:0] q [$];
    logic [37:0] e_item;
    logic [31:0] cap [64];
    int          rx_count = 0;
    bit          done_seen = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_w;
    logic [5:0]  prev_t;

    msg_schedule dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .MA    (MA),
        .MD    (MD),
        .W     (W),
        .T     (T),
        .W_VLD (W_VLD),
        .W_RDY (W_RDY),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc = cyc + 1;

    assign MD = alt_sel ? alt[MA[3:0]] : mem[MA[3:0]];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    task automatic push_expected();
        logic [31:0] e [64];
        for (int i = 0; i < 16; i++) e[i] = mem[i];
        for (int i = 16; i < 64; i++)
            e[i] = ms1(e[i-2]) + e[i-7] + ms0(e[i-15]) + e[i-16];
        for (int i = 0; i < 64; i++) q.push_back({6'(i), e[i]});
    endtask

    // Monitor: compare every transfer against the scoreboard.
    always @(negedge CLK) begin
        if (!RST) begin
            if (prev_stall) begin
                chk("stall_W", 64'(W), 64'(prev_w));
                chk("stall_T", 64'(T), 64'(prev_t));
                chk("stall_VLD", 64'(W_VLD), 64'd1);
            end
            if (W_VLD && W_RDY) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word: got T=%0d W=%h expected none", T, W);
                end else begin
                    e_item = q.pop_front();
                    chk("word_T", 64'(T), 64'(e_item[37:32]));
                    chk("word_W", 64'(W), 64'(e_item[31:0]));
                end
                cap[T] = W;
                rx_count++;
            end
            if (DONE) begin
                done_seen = 1;
                done_cyc  = cyc;
                chk("done_count", 64'(rx_count), 64'd64);
                chk("done_qempty", 64'(q.size()), 64'd0);
            end
            prev_stall = W_VLD && !W_RDY;
            prev_w     = W;
            prev_t     = T;
        end else begin
            prev_stall = 0;
        end
    end

    // Run one block; mode 0 ready-high, 1 random ready,
    // 2 random plus stalls at T=15/63, 3 random plus START at T=10.
    task automatic stream(input int mode);
        bit s15 = 0;
        bit s63 = 0;
        bit sb = 0;
        int n = 0;
        push_expected();
        rx_count  = 0;
        done_seen = 0;
        W_RDY     = 1'b1;
        START     = 1'b1;
        start_cyc = cyc + 1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        while (!done_seen && n < 3000) begin
            n++;
            if (mode == 2 && W_VLD && T == 6'd15 && !s15) begin
                s15   = 1;
                W_RDY = 1'b0;
                repeat (5) begin
                    @(posedge CLK);
                    #1;
                    chk("hold_T15", 64'(T), 64'd15);
                    chk("hold_MA15", 64'(MA), 64'd15);
                end
            end else if (mode == 2 && W_VLD && T == 6'd63 && !s63) begin
                s63   = 1;
                W_RDY = 1'b0;
                repeat (5) begin
                    @(posedge CLK);
                    #1;
                    chk("hold_T63", 64'(T), 64'd63);
                    chk("hold_busy63", 64'(BUSY), 64'd1);
                end
            end else if (mode == 3 && W_VLD && T == 6'd10 && !sb) begin
                sb      = 1;
                W_RDY   = 1'b0;
                alt_sel = 1'b1;
                START   = 1'b1;
                @(posedge CLK);
                #1;
                START   = 1'b0;
                alt_sel = 1'b0;
            end else begin
                W_RDY = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                @(posedge CLK);
                #1;
            end
        end
        if (!done_seen) begin
            checks++;
            failures++;
            $display("FAIL timeout: got no DONE expected DONE within budget");
        end
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 16; i++) mem[i] = $urandom();
    endtask

    initial begin
        int n;
        RST     = 1'b1;
        START   = 1'b0;
        W_RDY   = 1'b0;
        alt_sel = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            alt[i] = '0;
        end
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_W", 64'(W), 64'd0);
        chk("rst_T", 64'(T), 64'd0);
        chk("rst_VLD", 64'(W_VLD), 64'd0);
        chk("rst_MA", 64'(MA), 64'd0);
        chk("rst_BUSY", 64'(BUSY), 64'd0);
        chk("rst_DONE", 64'(DONE), 64'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // "abc" block
        mem[0]  = 32'h61626380;
        mem[15] = 32'h00000018;
        stream(0);
        chk("abc_W0", 64'(cap[0]), 64'h61626380);
        chk("abc_W15", 64'(cap[15]), 64'h00000018);
        chk("abc_W16", 64'(cap[16]), 64'h61626380);
        chk("abc_W17", 64'(cap[17]), 64'h000F0000);
        chk("abc_done_lat", 64'(done_cyc - start_cyc), 64'd65);
        chk("abc_busy_end", 64'(BUSY), 64'd0);

        // stalls at T=15 and T=63
        rand_mem();
        stream(2);

        // START while busy, then a fresh block from the new data
        rand_mem();
        for (int i = 0; i < 16; i++) alt[i] = $urandom();
        stream(3);
        for (int i = 0; i < 16; i++) mem[i] = alt[i];
        stream(1);
        chk("fresh_W0", 64'(cap[0]), 64'(alt[0]));

        // reset mid-stream
        rand_mem();
        push_expected();
        W_RDY = 1'b1;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        n = 0;
        while (!(W_VLD && T == 6'd30) && n < 200) begin
            n++;
            @(posedge CLK);
            #1;
        end
        chk("mid_reached_T30", 64'(T), 64'd30);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_VLD", 64'(W_VLD), 64'd0);
        chk("mid_rst_BUSY", 64'(BUSY), 64'd0);
        chk("mid_rst_DONE", 64'(DONE), 64'd0);
        chk("mid_rst_MA", 64'(MA), 64'd0);
        chk("mid_rst_T", 64'(T), 64'd0);
        q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        rand_mem();
        stream(1);

        // modular wrap: all ones
        for (int i = 0; i < 16; i++) mem[i] = 32'hFFFFFFFF;
        stream(1);
        chk("wrap_W16", 64'(cap[16]), 64'h203FFFFC);

        // random blocks with random ready
        for (int b = 0; b < 50; b++) begin
            rand_mem();
            stream(1);
        end

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msg_schedule.md
# msg_schedule

Message-schedule stage that sits directly upstream of the SHA-256 compressor. It reads one 16-word message block through the same address/data port convention the controller uses (MA out, MD in). It then streams the 64 expanded schedule words W0..W63 to the compressor over a valid/ready handshake, one word per cycle when not stalled. The block holds a 16-word sliding window and computes W16..W63 on the fly.

## Interface
- No parameters; round count fixed at 64, block size fixed at 16 words.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  single-cycle request to expand a new block; ignored unless IDLE.
- MA  out  8  word address into message block; only 0..15 issued; bits [7:4] always 0.
- MD  in  32  message word at MA; combinational read, valid in same cycle as MA.
- W  out  32  schedule word W_T.
- T  out  6  round index of W.
- W_VLD  out  1  W/T valid.
- W_RDY  in  1  compressor accepts W this cycle.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse after W63 is transferred.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE + START=1 -> RUN; t<=0, MA<=0, BUSY<=1.
- Produce condition in RUN: W_VLD==0 or W_RDY==1.
- On each produce edge, new word X is computed:
  - t<16: X = MD.
  - t>=16: X = s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2^32.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Also on each produce edge:
  - Window: win[0]=W(t-16) .. win[15]=W(t-1). Shift down one, X into win[15].
  - Output register: W<=X, T<=t, W_VLD<=1.
  - t<=t+1; MA<=min(t+1,15).
- After the produce with t=63 -> FLUSH; no further words are generated.
- FLUSH: on W_VLD && W_RDY -> W_VLD<=0, DONE<=1 for one cycle, BUSY<=0, -> IDLE.
- In RUN, a transfer (W_VLD && W_RDY) and a produce occur on the same edge, giving back-to-back throughput.
- Stall (W_VLD=1, W_RDY=0): W, T, MA, t and window all held stable; no produce.
- START while BUSY: ignored, no effect on the stream.
- START on the same edge DONE is asserted: ignored, since state is not yet IDLE.
- Word addition wraps modulo 2^32; carries are discarded.

## Timing
- Reset values: W=0, T=0, W_VLD=0, MA=0, BUSY=0, DONE=0, state IDLE, window cleared.
- RST mid-operation: all of the above reset immediately (asynchronous). The partial stream is abandoned; the next block needs a new START.
- Latency: START sampled at edge k -> W0 valid after edge k+1, i.e. 2 cycles from START assertion.
- W_RDY held high: W_t valid in cycle k+1+t; W63 after edge k+64.
- DONE asserts after edge k+65; BUSY falls on the same edge.
- W_RDY is not required to be stable; W_VLD never drops without a transfer.
- MD is sampled only on produce edges with t<16. MD may change freely at all other times.

## Test plan
- "abc" block: after RST, load M = {0x61626380, 14×0x00000000, 0x00000018}, pulse START, hold W_RDY=1.
  - Required: W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000.
  - Required: T increments 0..63 on consecutive cycles, DONE pulses once after edge k+65.
- Random blocks versus a reference model: 50 random 16-word blocks, W_RDY randomly toggled.
  - Required: all 64 words match the model in order, no duplicates or skips.
  - Required: W/T stable whenever W_VLD=1 and W_RDY=0.
- Stall at boundary: deassert W_RDY for 5 cycles while T=15, and again while T=63.
  - Required: W and T held; MA stays 15; the stream resumes without loss.
  - Required: DONE only after W63 is accepted.
- START while busy: pulse START at T=10 with a different block on MD.
  - Required: stream unchanged; after DONE, a new START begins a fresh block with W0 from the new MD.
- Reset mid-stream: assert RST at T=30.
  - Required: W_VLD, BUSY, DONE, MA and T go to 0 immediately.
  - Required: a following START yields a correct full 64-word stream.
- Modular arithmetic: all words 0xFFFFFFFF.
  - Required: W16 = s1(0xFFFFFFFF) + 0xFFFFFFFF + s0(0xFFFFFFFF) + 0xFFFFFFFF mod 2^32, matching the model bit-exactly.
